park_slot_debounce: RTL and testbench

- Front-end conditioner for the 8 parking-slot occupancy sensors.
- Synchronises and debounces the raw, bouncy sensor inputs into a clean, stable occupancy vector `car`.
- `car` feeds the occupancy counter / 7-segment display stage.
- Also produces per-slot entry/exit strobes and a global change strobe for downstream logging or gate logic.

---
 rtl/park_slot_debounce.sv | 142 ++++++++++++++
 tb/tb_park_slot_debounce.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/park_slot_debounce.sv
// Parking-slot sensor conditioner: 2-flop sync, tick-paced debounce, settle FSM, edge strobes.
// Optional sticky change interrupt enabled by defining PARK_IRQ_EN.
module park_slot_debounce #(
   parameter int unsigned NUM_SLOTS      = 8,
   parameter int unsigned TICK_DIV       = 100000,
   parameter int unsigned DEBOUNCE_TICKS = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_SLOTS-1:0] sensor_raw,
   output logic [NUM_SLOTS-1:0] car,
   output logic                 car_valid,
   output logic [NUM_SLOTS-1:0] entered,
   output logic [NUM_SLOTS-1:0] left,
   output logic                 change,
   output logic                 irq,
   input  logic                 irq_clr
);

   localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned CW = (DEBOUNCE_TICKS > 0) ? $clog2(DEBOUNCE_TICKS + 1) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   typedef enum logic {SETTLE, RUN} state_e;

   state_e               state_q, state_d;
   logic [CW-1:0]        settle_q, settle_d;
   logic [PW-1:0]        pre_q, pre_d;
   logic                 tick;
   logic [NUM_SLOTS-1:0] sync1_q, sync_q;
   logic [NUM_SLOTS-1:0] car_q, car_d;
   logic [CW-1:0]        cnt_q [NUM_SLOTS];
   logic [CW-1:0]        cnt_d [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] ent_q, ent_d, left_q, left_d;
   logic                 chg_q, chg_d;
   logic                 strobe_en;

   // FSM: state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= SETTLE;
         settle_q <= '0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
      end
   end

   // FSM: next state
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      if (state_q == SETTLE && tick) begin
         if (settle_q == CNT_LAST) begin
            state_d  = RUN;
            settle_d = '0;
         end else begin
            settle_d = settle_q + CW'(1);
         end
      end
   end

   // FSM: outputs
   always_comb begin
      car_valid = 1'b0;
      strobe_en = 1'b0;
      if (state_q == RUN) begin
         car_valid = 1'b1;
         strobe_en = 1'b1;
      end
   end

   assign tick  = (pre_q == PRE_LAST);
   assign pre_d = tick ? '0 : pre_q + PW'(1);

   // A slot flips only after DEBOUNCE_TICKS consecutive mismatching ticks.
   always_comb begin
      car_d = car_q;
      cnt_d = cnt_q;
      if (tick) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            if (sync_q[i] == car_q[i]) begin
               cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
               car_d[i] = sync_q[i];
               cnt_d[i] = '0;
            end else begin
               cnt_d[i] = cnt_q[i] + CW'(1);
            end
         end
      end
      ent_d  = strobe_en ? (car_d & ~car_q) : '0;
      left_d = strobe_en ? (~car_d & car_q) : '0;
      chg_d  = |(ent_d | left_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_q   <= '0;
         sync1_q <= '0;
         sync_q  <= '0;
         car_q   <= '0;
         ent_q   <= '0;
         left_q  <= '0;
         chg_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_SLOTS; i++) cnt_q[i] <= '0;
      end else begin
         pre_q   <= pre_d;
         sync1_q <= sensor_raw;
         sync_q  <= sync1_q;
         car_q   <= car_d;
         ent_q   <= ent_d;
         left_q  <= left_d;
         chg_q   <= chg_d;
         cnt_q   <= cnt_d;
      end
   end

   assign car     = car_q;
   assign entered = ent_q;
   assign left    = left_q;
   assign change  = chg_q;

`ifdef PARK_IRQ_EN
   logic irq_q;

   // Set has priority over clear so a change coinciding with irq_clr is not lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       irq_q <= 1'b0;
      else if (chg_q)   irq_q <= 1'b1;
      else if (irq_clr) irq_q <= 1'b0;
   end

   assign irq = irq_q;
`else
   logic unused_irq_clr;
   assign unused_irq_clr = irq_clr;
   assign irq            = 1'b0;
`endif

endmodule

// File: tb/tb_park_slot_debounce.sv
// Self-checking bench for park_slot_debounce: directed scenarios with literal expectations
// plus randomized bouncing inputs checked every cycle against a behavioural model.
module tb_park_slot_debounce;

   localparam int NS = 8;
   localparam int TD = 4;
   localparam int DT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic [NS-1:0] sensor_raw = '0;
   logic          irq_clr = 1'b0;
   logic [NS-1:0] car, entered, left;
   logic          car_valid, change, irq;

   always #5 clk = ~clk;

   park_slot_debounce #(
      .NUM_SLOTS(NS),
      .TICK_DIV(TD),
      .DEBOUNCE_TICKS(DT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .sensor_raw(sensor_raw),
      .car(car),
      .car_valid(car_valid),
      .entered(entered),
      .left(left),
      .change(change),
      .irq(irq),
      .irq_clr(irq_clr)
   );

   int n_chk  = 0;
   int n_pass = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: edges counted since reset release; ticks on every TD-th edge;
   // the debouncer sees the raw level from two edges earlier; a slot flips once it has
   // disagreed with car on DT ticks in a row; strobes only once DT ticks have elapsed.
   logic [NS-1:0] m_car = '0, m_ent = '0, m_left = '0;
   logic          m_chg = 1'b0, m_irq = 1'b0, m_valid = 1'b0;
   int            m_edges = 0, m_ticks = 0;
   int            m_run [NS];
   logic [NS-1:0] rawq [$];

   initial for (int i = 0; i < NS; i++) m_run[i] = 0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_car = '0; m_ent = '0; m_left = '0;
         m_chg = 1'b0; m_irq = 1'b0; m_valid = 1'b0;
         m_edges = 0; m_ticks = 0;
         for (int i = 0; i < NS; i++) m_run[i] = 0;
         rawq.delete();
      end else begin
         logic [NS-1:0] s;
`ifdef PARK_IRQ_EN
         if (m_chg) m_irq = 1'b1;
         else if (irq_clr) m_irq = 1'b0;
`endif
         m_edges++;
         s = (rawq.size() >= 2) ? rawq[rawq.size()-2] : '0;
         rawq.push_back(sensor_raw);
         if (rawq.size() > 4) void'(rawq.pop_front());
         m_ent = '0; m_left = '0;
         if (m_edges % TD == 0) begin
            for (int i = 0; i < NS; i++) begin
               if (s[i] != m_car[i]) begin
                  m_run[i]++;
                  if (m_run[i] == DT) begin
                     m_run[i] = 0;
                     m_car[i] = s[i];
                     if (m_ticks >= DT) begin
                        if (s[i]) m_ent[i] = 1'b1;
                        else      m_left[i] = 1'b1;
                     end
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            if (m_ticks < DT) m_ticks++;
         end
         m_chg   = |(m_ent | m_left);
         m_valid = (m_ticks >= DT);
      end
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("car",       car,       m_car);
         check("car_valid", car_valid, m_valid);
         check("entered",   entered,   m_ent);
         check("left",      left,      m_left);
         check("change",    change,    m_chg);
         check("irq",       irq,       m_irq);
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
      #1;
   endtask

   task automatic wait_change(input string name, input int max_cyc);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < max_cyc && !seen; i++) begin
         @(negedge clk);
         if (change) seen = 1'b1;
      end
      #1;
      if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   initial begin
      #1 rst_n = 1'b0;
      cmp_en = 1'b1;
      cyc(2);
      check("rst_car",   car,       32'h0);
      check("rst_valid", car_valid, 32'h0);
      check("rst_irq",   irq,       32'h0);

      // 1: idle start-up, valid rises on the 12th edge after release
      rst_n = 1'b1;
      cyc(11);
      check("s1_valid_early", car_valid, 32'h0);
      cyc(1);
      check("s1_valid_on", car_valid, 32'h1);
      check("s1_car",      car,       32'h0);
      cyc(8);

      // 2: clean rise on slots 0 and 2
      sensor_raw = 8'h05;
      wait_change("s2", 40);
      check("s2_entered", entered, 32'h05);
      check("s2_left",    left,    32'h00);
      check("s2_car",     car,     32'h05);
`ifdef PARK_IRQ_EN
      cyc(1);
      check("s2_irq_set", irq, 32'h1);
      irq_clr = 1'b1;
      cyc(1);
      irq_clr = 1'b0;
      check("s2_irq_clr", irq, 32'h0);
`endif
      cyc(6);

      // 3: bounce on slot 1 never accepted
      sensor_raw = 8'h07; cyc(TD);
      sensor_raw = 8'h05; cyc(TD);
      sensor_raw = 8'h07; cyc(TD);
      sensor_raw = 8'h05; cyc(20);
      check("s3_car", car, 32'h05);

      // 4: simultaneous leave of 0/2 and arrival on 1/7
      sensor_raw = 8'h82;
      wait_change("s4", 40);
`ifdef PARK_IRQ_EN
      irq_clr = 1'b1;
`endif
      check("s4_left",    left,    32'h05);
      check("s4_entered", entered, 32'h82);
      check("s4_car",     car,     32'h82);
      cyc(1);
      irq_clr = 1'b0;
`ifdef PARK_IRQ_EN
      check("s4_irq_held", irq, 32'h1);
`endif
      cyc(4);

      // 6: reset while the new level has two ticks of progress
      sensor_raw = 8'h10;
      cyc(2 + 2 * TD);
      check("s6_car_pending", car, 32'h82);
      rst_n = 1'b0;
      #1;
      check("s6_rst_car",   car,       32'h0);
      check("s6_rst_valid", car_valid, 32'h0);
      check("s6_rst_strb",  {entered, left, 7'd0, change, 7'd0, irq}, 32'h0);
      cyc(2);
      rst_n = 1'b1;
      cyc(11);
      check("s6_car_early", car, 32'h00);
      cyc(1);
      check("s6_car_full", car, 32'h10);

      // 5: all slots occupied from power-up, no entry strobes
      rst_n = 1'b0;
      sensor_raw = 8'hFF;
      cyc(2);
      rst_n = 1'b1;
      cyc(12);
      check("s5_car",   car,       32'hFF);
      check("s5_valid", car_valid, 32'h1);
      cyc(20);

      // randomized bouncing sensors
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 5) == 0) sensor_raw[$urandom_range(0, NS-1)] ^= 1'b1;
         irq_clr = ($urandom_range(0, 9) == 0);
         if (c == 1500) begin
            rst_n = 1'b0;
            cyc(1);
            rst_n = 1'b1;
         end
         cyc(1);
      end

      cmp_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
